// File: rtl/cog_ctr_gate_pkg.sv
// Shared definitions for the cog counter measurement sequencer: FSM states,
// CTR word field layout, counter mode codes and the strobe bundle driven to cog_ctr.
package cog_ctr_gate_pkg;

  typedef enum logic [3:0] {
    ST_OFF  = 4'd0,
    ST_IDLE = 4'd1,
    ST_CLR  = 4'd2,
    ST_FRQ  = 4'd3,
    ST_PHS  = 4'd4,
    ST_ARM  = 4'd5,
    ST_RUN  = 4'd6,
    ST_STOP = 4'd7,
    ST_CAPT = 4'd8
  } gate_state_e;

  localparam int unsigned CTR_MODE_LSB   = 26;
  localparam int unsigned CTR_MODE_W     = 5;
  localparam int unsigned CTR_PLLDIV_LSB = 23;
  localparam int unsigned CTR_BPIN_LSB   = 9;
  localparam int unsigned CTR_APIN_LSB   = 0;

  localparam logic [4:0] MODE_OFF         = 5'd0;
  localparam logic [4:0] MODE_PLL_INT     = 5'd1;
  localparam logic [4:0] MODE_PLL_SINGLE  = 5'd2;
  localparam logic [4:0] MODE_PLL_DIFF    = 5'd3;
  localparam logic [4:0] MODE_NCO_SINGLE  = 5'd4;
  localparam logic [4:0] MODE_NCO_DIFF    = 5'd5;
  localparam logic [4:0] MODE_DUTY_SINGLE = 5'd6;
  localparam logic [4:0] MODE_DUTY_DIFF   = 5'd7;
  localparam logic [4:0] MODE_POS         = 5'd8;
  localparam logic [4:0] MODE_POS_FB      = 5'd9;
  localparam logic [4:0] MODE_POSEDGE     = 5'd10;
  localparam logic [4:0] MODE_POSEDGE_FB  = 5'd11;

  // Writing this CTR word halts the counter (mode field OFF).
  localparam logic [31:0] CTR_WORD_OFF = 32'd0;

  typedef struct packed {
    logic        setctr;
    logic        setfrq;
    logic        setphs;
    logic [31:0] data;
  } ctr_drive_t;

  localparam ctr_drive_t DRIVE_NONE = '{setctr: 1'b0, setfrq: 1'b0, setphs: 1'b0, data: 32'd0};

  // Assemble a CTR word: mode in [30:26], PLLDIV [25:23], BPIN [14:9], APIN [5:0].
  function automatic logic [31:0] ctr_word(input logic [4:0] mode_code,
                                           input logic [2:0] plldiv,
                                           input logic [5:0] bpin,
                                           input logic [5:0] apin);
    return {1'b0, mode_code, plldiv, 8'd0, bpin, 3'd0, apin};
  endfunction

  function automatic logic [4:0] ctr_mode_field(input logic [31:0] ctr_w);
    return ctr_w[CTR_MODE_LSB +: CTR_MODE_W];
  endfunction

endpackage

// File: rtl/cog_ctr_gate.sv
// Gated-measurement sequencer for one cog_ctr: programs CTR/FRQ/PHS, lets the
// counter accumulate for max(gate_len,1) edges, stops it and captures PHS.
module cog_ctr_gate
  import cog_ctr_gate_pkg::*;
#(
  parameter int GW = 32
) (
  input  logic          clk_cog,
  input  logic          res,
  input  logic          req,
  output logic          ack,
  input  logic [31:0]   mode,
  input  logic [31:0]   frq_val,
  input  logic [31:0]   phs_init,
  input  logic [GW-1:0] gate_len,
  input  logic          abort,
  input  logic [32:0]   phs_in,
  output logic          setctr,
  output logic          setfrq,
  output logic          setphs,
  output logic [31:0]   data,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [32:0]   result
);

  localparam logic [GW-1:0] GCNT_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0] GCNT_ONE  = {{(GW-1){1'b0}}, 1'b1};

  gate_state_e   state_q, state_d, fsm_next_s;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [GW-1:0] gate_q;
  logic [31:0]   mode_q, frq_q, phs_init_q;
  ctr_drive_t    drv_q;
  logic          busy_q, done_q, aborted_q;
  logic [32:0]   result_q;
  logic          accept_s, abortable_s, abort_take_s;

  // Strobe/data pattern presented to cog_ctr while the FSM sits in a given state.
  function automatic ctr_drive_t drive_for(input gate_state_e st,
                                           input logic [31:0] mode_w,
                                           input logic [31:0] frq_w,
                                           input logic [31:0] phs_w);
    ctr_drive_t d;
    d = DRIVE_NONE;
    case (st)
      ST_OFF, ST_CLR, ST_STOP: begin
        d.setctr = 1'b1;
        d.data   = CTR_WORD_OFF;
      end
      ST_FRQ: begin
        d.setfrq = 1'b1;
        d.data   = frq_w;
      end
      ST_PHS: begin
        d.setphs = 1'b1;
        d.data   = phs_w;
      end
      ST_ARM: begin
        d.setctr = 1'b1;
        d.data   = mode_w;
      end
      default: d = DRIVE_NONE;
    endcase
    return d;
  endfunction

  assign accept_s     = req && (state_q == ST_IDLE) && !res;
  assign abortable_s  = (state_q == ST_CLR) || (state_q == ST_FRQ) || (state_q == ST_PHS) ||
                        (state_q == ST_ARM) || (state_q == ST_RUN) || (state_q == ST_STOP);
  assign abort_take_s = abort && abortable_s;

  // Next-state and gate down-counter; RUN lasts exactly gcnt cycles.
  always_comb begin
    fsm_next_s = state_q;
    gcnt_d     = gcnt_q;
    case (state_q)
      ST_OFF:  fsm_next_s = ST_IDLE;
      ST_IDLE: begin
        if (req) begin
          fsm_next_s = ST_CLR;
        end else begin
          fsm_next_s = ST_IDLE;
        end
      end
      ST_CLR:  fsm_next_s = ST_FRQ;
      ST_FRQ:  fsm_next_s = ST_PHS;
      ST_PHS: begin
        fsm_next_s = ST_ARM;
        if (gate_q == GCNT_ZERO) begin
          gcnt_d = GCNT_ZERO;
        end else begin
          gcnt_d = gate_q - GCNT_ONE;
        end
      end
      ST_ARM: begin
        if (gcnt_q != GCNT_ZERO) begin
          fsm_next_s = ST_RUN;
        end else begin
          fsm_next_s = ST_STOP;
        end
      end
      ST_RUN: begin
        gcnt_d = gcnt_q - GCNT_ONE;
        if (gcnt_q <= GCNT_ONE) begin
          fsm_next_s = ST_STOP;
        end else begin
          fsm_next_s = ST_RUN;
        end
      end
      ST_STOP: fsm_next_s = ST_CAPT;
      ST_CAPT: fsm_next_s = ST_IDLE;
      default: fsm_next_s = ST_OFF;
    endcase

    if (abort_take_s) begin
      state_d = ST_OFF;
    end else begin
      state_d = fsm_next_s;
    end
  end

  // State, operand latches and all registered outputs; outputs track the state being entered.
  always_ff @(posedge clk_cog) begin
    if (res) begin
      state_q   <= ST_OFF;
      gcnt_q    <= GCNT_ZERO;
      drv_q     <= drive_for(ST_OFF, 32'd0, 32'd0, 32'd0);
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      result_q  <= 33'd0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      drv_q   <= drive_for(state_d, mode_q, frq_q, phs_init_q);
      busy_q  <= (state_d != ST_IDLE);
      if (accept_s) begin
        mode_q     <= mode;
        frq_q      <= frq_val;
        phs_init_q <= phs_init;
        gate_q     <= gate_len;
      end
      if (abort_take_s) begin
        done_q    <= 1'b1;
        aborted_q <= 1'b1;
      end else if (state_q == ST_CAPT) begin
        done_q    <= 1'b1;
        aborted_q <= 1'b0;
        result_q  <= phs_in;
      end else begin
        done_q    <= 1'b0;
      end
    end
  end

  assign ack     = accept_s;
  assign setctr  = drv_q.setctr;
  assign setfrq  = drv_q.setfrq;
  assign setphs  = drv_q.setphs;
  assign data    = drv_q.data;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign result  = result_q;

endmodule

// File: tb/tb_cog_ctr_gate.sv
// Directed bench for cog_ctr_gate with a behavioural cog_ctr and a done-driven scoreboard.
module tb_cog_ctr_gate;
  import cog_ctr_gate_pkg::*;

  logic        clk = 1'b0;
  logic        res, req, abort, ack;
  logic [31:0] mode, frq_val, phs_init, gate_len;
  logic [32:0] phs_in;
  logic        setctr, setfrq, setphs, busy, done, aborted;
  logic [31:0] data;
  logic [32:0] result;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        ab;
    logic [32:0] res;
  } exp_t;
  exp_t        sb_q[$];
  logic [34:0] log_q[$];
  logic [32:0] last_res;

  logic [31:0] ctr_m = 32'd0;
  logic [31:0] frq_m = 32'd0;
  logic [32:0] phs_m = 33'd0;

  always #5 clk = ~clk;

  cog_ctr_gate #(.GW(32)) dut (
    .clk_cog(clk), .res(res), .req(req), .ack(ack), .mode(mode), .frq_val(frq_val),
    .phs_init(phs_init), .gate_len(gate_len), .abort(abort), .phs_in(phs_in),
    .setctr(setctr), .setfrq(setfrq), .setphs(setphs), .data(data), .busy(busy),
    .done(done), .aborted(aborted), .result(result)
  );

  // Behavioural cog_ctr: any non-off mode adds frq each edge, bit32 is the last carry.
  always @(posedge clk) begin
    if (setctr) ctr_m <= data;
    if (setfrq) frq_m <= data;
    if (setphs) phs_m <= {1'b0, data};
    else if (ctr_mode_field(ctr_m) != MODE_OFF) phs_m <= {1'b0, phs_m[31:0]} + {1'b0, frq_m};
  end
  assign phs_in = phs_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every done pulse consumes one expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("done_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("done_aborted", {63'd0, aborted}, {63'd0, e.ab});
        chk("done_result", {31'd0, result}, {31'd0, e.res});
      end
    end
  end

  // Strobe trace for order checks.
  always @(negedge clk) begin
    if (setctr || setfrq || setphs) log_q.push_back({setctr, setfrq, setphs, data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] exp_phs(input logic [31:0] f, input logic [31:0] p,
                                          input logic [31:0] g);
    logic [32:0] acc;
    int unsigned n;
    acc = {1'b0, p};
    n = (g == 32'd0) ? 1 : g;
    for (int unsigned i = 0; i < n; i++) acc = {1'b0, acc[31:0]} + {1'b0, f};
    return acc;
  endfunction

  task automatic start_meas(input logic [31:0] m, input logic [31:0] f, input logic [31:0] p,
                            input logic [31:0] g, input bit expect_done);
    int n;
    mode = m; frq_val = f; phs_init = p; gate_len = g; req = 1'b1;
    n = 0;
    #1;
    while (ack !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("ack_seen", {63'd0, ack}, 64'd1);
    if (expect_done) sb_q.push_back('{ab: 1'b0, res: exp_phs(f, p, g)});
    log_q.delete();
    @(negedge clk);
    req = 1'b0;
    chk("busy_after_ack", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk); n++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("idle_not_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_order(input logic [31:0] m, input logic [31:0] f, input logic [31:0] p);
    logic [34:0] exp_log[5];
    exp_log[0] = {3'b100, 32'd0};
    exp_log[1] = {3'b010, f};
    exp_log[2] = {3'b001, p};
    exp_log[3] = {3'b100, m};
    exp_log[4] = {3'b100, 32'd0};
    chk("strobe_count", 64'(log_q.size()), 64'd5);
    if (log_q.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("strobe_order", {29'd0, log_q[i]}, {29'd0, exp_log[i]});
    end
  endtask

  initial begin
    logic [31:0] nco;
    nco = ctr_word(MODE_NCO_SINGLE, 3'd0, 6'd0, 6'd0);
    res = 1'b1; req = 1'b0; abort = 1'b0;
    mode = 32'd0; frq_val = 32'd0; phs_init = 32'd0; gate_len = 32'd0;
    repeat (3) @(negedge clk);
    req = 1'b1; #1;
    chk("rst_ack", {63'd0, ack}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_aborted", {63'd0, aborted}, 64'd0);
    chk("rst_result", {31'd0, result}, 64'd0);
    chk("rst_setctr", {63'd0, setctr}, 64'd1);
    chk("rst_data", {32'd0, data}, 64'd0);
    req = 1'b0; res = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {63'd0, busy}, 64'd0);
    chk("post_rst_setctr", {63'd0, setctr}, 64'd0);

    // Plain NCO accumulation and mid-run carry.
    start_meas(nco, 32'd1, 32'd0, 32'd100, 1'b1);
    wait_done(160);
    start_meas(nco, 32'h8000_0000, 32'd0, 32'd3, 1'b1);
    wait_done(40);
    // gate 0 and gate 1 give the same single edge.
    start_meas(nco, 32'd5, 32'd10, 32'd0, 1'b1);
    wait_done(40);
    check_order(nco, 32'd5, 32'd10);
    start_meas(nco, 32'd5, 32'd10, 32'd1, 1'b1);
    wait_done(40);
    check_order(nco, 32'd5, 32'd10);
    last_res = 33'd15;

    // Abort during RUN keeps the previous result.
    start_meas(nco, 32'd3, 32'd0, 32'd1000, 1'b0);
    repeat (20) @(negedge clk);
    abort = 1'b1;
    sb_q.push_back('{ab: 1'b1, res: last_res});
    @(negedge clk);
    abort = 1'b0;
    chk("abort_setctr", {63'd0, setctr}, 64'd1);
    chk("abort_data", {32'd0, data}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("abort_done_cleared", {63'd0, done}, 64'd0);
    chk("abort_to_idle", {63'd0, busy}, 64'd0);

    // Reset in RUN: counter stopped, no done, status cleared.
    start_meas(nco, 32'd7, 32'd0, 32'd1000, 1'b0);
    repeat (20) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    chk("midrst_setctr", {63'd0, setctr}, 64'd1);
    chk("midrst_data", {32'd0, data}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd1);
    chk("midrst_aborted", {63'd0, aborted}, 64'd0);
    chk("midrst_result", {31'd0, result}, 64'd0);
    @(negedge clk);
    chk("midrst_idle", {63'd0, busy}, 64'd0);
    repeat (5) @(negedge clk);
    start_meas(nco, 32'd2, 32'd9, 32'd7, 1'b1);
    wait_done(40);

    // req together with abort in IDLE is accepted; held req is ignored while busy.
    mode = nco; frq_val = 32'd11; phs_init = 32'd4; gate_len = 32'd4;
    req = 1'b1; abort = 1'b1; #1;
    chk("req_abort_ack", {63'd0, ack}, 64'd1);
    sb_q.push_back('{ab: 1'b0, res: exp_phs(32'd11, 32'd4, 32'd4)});
    @(negedge clk);
    abort = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (busy !== 1'b1) break;
      chk("ack_while_busy", {63'd0, ack}, 64'd0);
      @(negedge clk);
    end
    chk("held_req_done", {63'd0, done}, 64'd1);
    chk("held_req_reaccept", {63'd0, ack}, 64'd1);
    sb_q.push_back('{ab: 1'b0, res: exp_phs(32'd11, 32'd4, 32'd4)});
    @(negedge clk);
    req = 1'b0;
    wait_done(40);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
